// File: rtl/arm_alu_pkg.sv
// arm_alu_pkg
//   Shared constants for the ARMv4 data-processing ALU:
//   - OP_* : 4-bit opcodes in the ARM data-processing encoding.
//   - FLAG_* : bit positions of N, Z, C and V inside the nzcv vector.
//   - Helpers that classify an opcode as a flag-only compare or a logical op.
package arm_alu_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_EOR = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_ADC = 4'd5;
  localparam logic [3:0] OP_SBC = 4'd6;
  localparam logic [3:0] OP_RSC = 4'd7;
  localparam logic [3:0] OP_TST = 4'd8;
  localparam logic [3:0] OP_TEQ = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_CMN = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12;
  localparam logic [3:0] OP_MOV = 4'd13;
  localparam logic [3:0] OP_BIC = 4'd14;
  localparam logic [3:0] OP_MVN = 4'd15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // TST/TEQ/CMP/CMN (8..11) always update the flags, whatever the S bit says.
  function automatic logic is_test_op(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

  // Logical ops touch only N and Z; C and V keep their previous values.
  function automatic logic is_logical_op(input logic [3:0] op);
    logic result;
    result = 1'b0;
    case (op)
      OP_AND, OP_EOR, OP_TST, OP_TEQ,
      OP_ORR, OP_MOV, OP_BIC, OP_MVN: result = 1'b1;
      default:                        result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/arm_alu_adder.sv
// arm_alu_adder
//   Single carry-in adder shared by every arithmetic opcode. The caller
//   pre-inverts / swaps operands so that subtraction is x + ~y + cin.
// Ports:
//   x_i, y_i  : operands exactly as fed to the adder
//   cin_i     : carry in
//   sum_o     : low WIDTH bits of x + y + cin
//   cout_o    : carry out of the top bit (no-borrow for subtraction)
//   ovf_o     : signed overflow of the addition as seen by the adder
module arm_alu_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  logic [WIDTH:0] full_sum;

  assign full_sum = {1'b0, x_i} + {1'b0, y_i} + {{WIDTH{1'b0}}, cin_i};
  assign sum_o    = full_sum[WIDTH-1:0];
  assign cout_o   = full_sum[WIDTH];
  // Overflow: both adder inputs share a sign and the sum's sign differs.
  assign ovf_o    = (x_i[WIDTH-1] == y_i[WIDTH-1]) &&
                    (full_sum[WIDTH-1] != x_i[WIDTH-1]);

endmodule

// File: rtl/arm_alu.sv
// arm_alu
//   ARMv4 data-processing ALU for the execute stage. Result and NZCV flags are
//   registered; one operation is accepted every cycle with no handshake and
//   its result appears after the next rising edge.
// Ports:
//   clk        : rising-edge clock
//   reset      : synchronous, active-high; clears ALU_out and nzcv
//   A          : first operand (Rn)
//   B          : second operand (shifter output)
//   ALU_Sel    : opcode, ARM data-processing encoding
//   set_flags  : S bit; enables NZCV update for any opcode
//   ALU_out    : registered result, [31:0] value, [63:32] always zero
//   nzcv       : registered flags, [3]=N [2]=Z [1]=C [0]=V
module arm_alu
  import arm_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [3:0]         ALU_Sel,
  input  logic               set_flags,
  output logic [2*WIDTH-1:0] ALU_out,
  output logic [3:0]         nzcv
);

  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       nzcv_q, nzcv_d;

  logic [WIDTH-1:0] add_x, add_y;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             add_ovf;
  logic             carry_in;
  logic             flags_en;

  // Architectural carry feeds ADC/SBC/RSC; it is the value before this edge.
  assign carry_in = nzcv_q[FLAG_C];

  // Operand steering: reverse ops swap A/B, subtracts invert the subtrahend
  // and use cin=1 (or the carry flag for the with-carry forms).
  always_comb begin
    add_x   = A;
    add_y   = B;
    add_cin = 1'b0;
    case (ALU_Sel)
      OP_SUB, OP_CMP: begin
        add_y   = ~B;
        add_cin = 1'b1;
      end
      OP_RSB: begin
        add_x   = B;
        add_y   = ~A;
        add_cin = 1'b1;
      end
      OP_ADC: begin
        add_cin = carry_in;
      end
      OP_SBC: begin
        add_y   = ~B;
        add_cin = carry_in;
      end
      OP_RSC: begin
        add_x   = B;
        add_y   = ~A;
        add_cin = carry_in;
      end
      default: begin
        add_x   = A;
        add_y   = B;
        add_cin = 1'b0;
      end
    endcase
  end

  arm_alu_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .x_i    (add_x),
    .y_i    (add_y),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout),
    .ovf_o  (add_ovf)
  );

  // Result mux: logical results bypass the adder.
  always_comb begin
    result_d = add_sum;
    case (ALU_Sel)
      OP_AND, OP_TST: result_d = A & B;
      OP_EOR, OP_TEQ: result_d = A ^ B;
      OP_ORR:         result_d = A | B;
      OP_MOV:         result_d = B;
      OP_BIC:         result_d = A & ~B;
      OP_MVN:         result_d = ~B;
      default:        result_d = add_sum;
    endcase
  end

  assign flags_en = set_flags || is_test_op(ALU_Sel);

  always_comb begin
    nzcv_d = nzcv_q;
    if (flags_en) begin
      nzcv_d[FLAG_N] = result_d[WIDTH-1];
      nzcv_d[FLAG_Z] = (result_d == '0);
      if (!is_logical_op(ALU_Sel)) begin
        nzcv_d[FLAG_C] = add_cout;
        nzcv_d[FLAG_V] = add_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      nzcv_q   <= 4'b0000;
    end else begin
      result_q <= result_d;
      nzcv_q   <= nzcv_d;
    end
  end

  assign ALU_out = {{WIDTH{1'b0}}, result_q};
  assign nzcv    = nzcv_q;

endmodule

// File: tb/tb_arm_alu.sv
module tb_arm_alu;
  import arm_alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  ALU_Sel;
  logic        set_flags;
  logic [63:0] ALU_out;
  logic [3:0]  nzcv;

  always #5 clk = ~clk;

  arm_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .ALU_Sel   (ALU_Sel),
    .set_flags (set_flags),
    .ALU_out   (ALU_out),
    .nzcv      (nzcv)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- behavioural model ----------------
  // Arithmetic done in 64-bit integers: C from the unsigned range of the
  // true result, V from the signed range of the true result.
  logic [31:0] exp_res;
  logic [3:0]  exp_nzcv;
  logic        model_valid = 1'b0;

  function automatic void model_op(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic cin,
                                   output logic [31:0] res, output logic c,
                                   output logic v, output logic arith);
    longint ua, ub, sa, sb, u, s;
    int     ta, tb;
    logic   is_add;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ta = a; tb = b;
    sa = ta; sb = tb;
    arith = 1'b1; is_add = 1'b0; u = 0; s = 0; res = '0;
    case (op)
      4'd4, 4'd11: begin is_add = 1'b1; u = ua + ub; s = sa + sb; end
      4'd5:  begin is_add = 1'b1; u = ua + ub + cin; s = sa + sb + cin; end
      4'd2, 4'd10: begin u = ua - ub; s = sa - sb; end
      4'd3:  begin u = ub - ua; s = sb - sa; end
      4'd6:  begin u = ua - ub - (cin ? 0 : 1); s = sa - sb - (cin ? 0 : 1); end
      4'd7:  begin u = ub - ua - (cin ? 0 : 1); s = sb - sa - (cin ? 0 : 1); end
      default: arith = 1'b0;
    endcase
    if (arith) begin
      res = u[31:0];
      c   = is_add ? (u > 64'sd4294967295) : (u >= 0);
      v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else begin
      c = 1'b0; v = 1'b0;
      case (op)
        4'd0, 4'd8: res = a & b;
        4'd1, 4'd9: res = a ^ b;
        4'd12:      res = a | b;
        4'd13:      res = b;
        4'd14:      res = a & ~b;
        default:    res = ~b;
      endcase
    end
  endfunction

  always @(posedge clk) begin
    logic [31:0] r;
    logic c, v, arith;
    if (reset) begin
      exp_res     = '0;
      exp_nzcv    = 4'b0000;
      model_valid = 1'b1;
    end else if (model_valid) begin
      model_op(ALU_Sel, A, B, exp_nzcv[1], r, c, v, arith);
      exp_res = r;
      if (set_flags || (ALU_Sel >= 4'd8 && ALU_Sel <= 4'd11)) begin
        exp_nzcv[3] = r[31];
        exp_nzcv[2] = (r == 32'd0);
        if (arith) begin
          exp_nzcv[1] = c;
          exp_nzcv[0] = v;
        end
      end
    end
  end

  // ---------------- scoreboard: compare every cycle ----------------
  always @(negedge clk) begin
    if (model_valid) begin
      tests_run++;
      if (ALU_out !== {32'h0, exp_res} || nzcv !== exp_nzcv) begin
        tests_failed++;
        $display("FAIL model_cmp t=%0t op=%0d got out=%h nzcv=%b exp out=%h nzcv=%b",
                 $time, ALU_Sel, ALU_out, nzcv, {32'h0, exp_res}, exp_nzcv);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic sf);
    @(negedge clk);
    #1;
    reset = rst; ALU_Sel = op; A = a; B = b; set_flags = sf;
    @(posedge clk);
    #2;
  endtask

  // Hand-computed literal expectation, checked just after the edge.
  task automatic check_lit(input string name, input logic [31:0] res_exp,
                           input logic [3:0] nzcv_exp);
    tests_run++;
    if (ALU_out !== {32'h0, res_exp} || nzcv !== nzcv_exp) begin
      tests_failed++;
      $display("FAIL %s got out=%h nzcv=%b exp out=%h nzcv=%b",
               name, ALU_out, nzcv, {32'h0, res_exp}, nzcv_exp);
    end
  endtask

  task automatic op_lit(input string name, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic sf,
                        input logic [31:0] res_exp, input logic [3:0] nzcv_exp);
    drive(1'b0, op, a, b, sf);
    check_lit(name, res_exp, nzcv_exp);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] vec_a [6];
  logic [31:0] vec_b [6];

  initial begin
    reset = 1'b1; ALU_Sel = OP_MVN; A = 32'hDEAD_BEEF; B = 32'h1234_5678; set_flags = 1'b1;
    @(posedge clk); #2;
    drive(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1);
    check_lit("reset", 32'h0, 4'b0000);

    op_lit("add_1_1",      OP_ADD, 32'h1, 32'h1, 1'b1, 32'h2, 4'b0000);
    op_lit("add_carry",    OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h0, 4'b0110);
    op_lit("adc_cin1",     OP_ADC, 32'h1, 32'h1, 1'b1, 32'h3, 4'b0000);
    op_lit("add_ovf",      OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000, 4'b1001);
    op_lit("cmp_eq_nosf",  OP_CMP, 32'h5, 32'h5, 1'b0, 32'h0, 4'b0110);
    op_lit("cmp_lt",       OP_CMP, 32'h3, 32'h5, 1'b0, 32'hFFFF_FFFE, 4'b1000);
    op_lit("rsb",          OP_RSB, 32'h3, 32'h5, 1'b1, 32'h2, 4'b0010);
    op_lit("cmp_clr_c",    OP_CMP, 32'h3, 32'h5, 1'b1, 32'hFFFF_FFFE, 4'b1000);
    op_lit("sbc_cin0",     OP_SBC, 32'h5, 32'h2, 1'b1, 32'h2, 4'b0010);
    op_lit("add_nosf",     OP_ADD, 32'h10, 32'h20, 1'b0, 32'h30, 4'b0010);
    op_lit("preset_cv",    OP_ADD, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0, 4'b0111);
    op_lit("bic_keep_cv",  OP_BIC, 32'hFF, 32'h0F, 1'b1, 32'hF0, 4'b0011);
    op_lit("mvn_zero",     OP_MVN, 32'h0, 32'hFFFF_FFFF, 1'b1, 32'h0, 4'b0111);
    op_lit("teq_nosf",     OP_TEQ, 32'h5, 32'h5, 1'b0, 32'h0, 4'b0111);
    op_lit("rsc_cin1",     OP_RSC, 32'h3, 32'h5, 1'b1, 32'h2, 4'b0010);

    // Sweep every opcode over a few operand pairs, both S-bit values;
    // these are checked only against the model.
    vec_a[0] = 32'h0;          vec_b[0] = 32'h0;
    vec_a[1] = 32'hFFFF_FFFF;  vec_b[1] = 32'hFFFF_FFFF;
    vec_a[2] = 32'h8000_0000;  vec_b[2] = 32'h0000_0001;
    vec_a[3] = 32'h1234_5678;  vec_b[3] = 32'h8765_4321;
    vec_a[4] = 32'h7FFF_FFFF;  vec_b[4] = 32'h8000_0000;
    vec_a[5] = 32'h0000_0002;  vec_b[5] = 32'h0000_0003;
    for (int op = 0; op < 16; op++) begin
      for (int k = 0; k < 6; k++) begin
        drive(1'b0, op[3:0], vec_a[k], vec_b[k], k[0]);
        drive(1'b0, op[3:0], vec_b[k], vec_a[k], ~k[0]);
      end
    end

    // Carry-chain back-to-back ops with random operands.
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 4'($urandom_range(5, 7)), $urandom, $urandom, 1'b1);
    end

    // Mid-stream reset overrides an operation that would set flags.
    op_lit("pre_reset",    OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 4'b1010);
    drive(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1);
    check_lit("reset_mid", 32'h0, 4'b0000);
    op_lit("post_reset",   OP_SUB, 32'h5, 32'h2, 1'b1, 32'h3, 4'b0010);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/arm_alu.md
Name: arm_alu

Overview:
- ARMv4 data-processing ALU: 32-bit operands A and B, 4-bit opcode in the ARM data-processing encoding, registered 64-bit result and registered NZCV flags.
- Sits in the execute stage. The barrel shifter and multiplier are outside this block.
- Holds the architectural NZCV flags, which also supply the carry-in for ADC/SBC/RSC.

Parameters:
- WIDTH, 32, operand and result-word width. Only 32 is supported.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- A  input  32  first operand (Rn)
- B  input  32  second operand (shifter output)
- ALU_Sel  input  4  opcode, ARM data-processing encoding
- set_flags  input  1  S bit; when 1, NZCV updates for all opcodes
- ALU_out  output  64  registered result; [31:0] result, [63:32] always 0
- nzcv  output  4  registered flags; [3]=N, [2]=Z, [1]=C, [0]=V

Behaviour:
- Reset: the synchronous reset is sampled on the clk rising edge; ALU_out=0 and nzcv=4'b0000 on that edge. Reset has priority over every operation, including one in flight.
- Latency: one cycle. Inputs sampled at edge k give a result and flags visible after edge k.
- New operation every cycle; no handshake.
- Opcodes. Cin is the current registered nzcv[1]; ~ is bitwise NOT; all arithmetic is mod 2^32.
  - 0 AND: A&B
  - 1 EOR: A^B
  - 2 SUB: A-B
  - 3 RSB: B-A
  - 4 ADD: A+B
  - 5 ADC: A+B+Cin
  - 6 SBC: A-B-!Cin
  - 7 RSC: B-A-!Cin
  - 8 TST: A&B
  - 9 TEQ: A^B
  - 10 CMP: A-B
  - 11 CMN: A+B
  - 12 ORR: A|B
  - 13 MOV: B
  - 14 BIC: A&~B
  - 15 MVN: ~B
- ALU_out[31:0] receives the computed value for every opcode, including TST/TEQ/CMP/CMN. The register-file writeback suppression is done outside this block.
- Flag update enable: set_flags=1 OR opcode in {8,9,10,11}. When not enabled, nzcv holds its value.
- N = result[31].
- Z = (result[31:0]==0).
- Arithmetic C and V: all arithmetic ops are computed as X + ~Y + cin or X + Y + cin through a single 33-bit adder.
  - C = adder carry-out. For subtraction this means C=1 when there is no borrow, e.g. SUB with A>=B unsigned gives C=1.
  - V = signed overflow: the operand signs as fed to the adder are equal and the result sign differs.
- Logical ops (0,1,8,9,12,13,14,15): N and Z update; C and V are preserved. No shifter carry-in exists in this block.
- Simultaneous ADC/SBC/RSC with flag update: Cin is the old flag value; the new C is written on the same edge.

Decomposition:
- Package arm_alu_pkg holds:
  - 4-bit opcode localparams OP_AND..OP_MVN, values 0-15 as listed.
  - Flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module, arm_alu_adder: 32-bit operands plus cin; outputs sum[31:0], cout and ovf.
  - The top module selects operand inversion/swap and cin per opcode, and muxes in the logical results.

Test Plan:
- Reset: hold reset=1 for 2 edges with any inputs -> ALU_out=0, nzcv=0000. Assert reset again mid-stream -> both cleared on that edge.
- A=1, B=1, ALU_Sel=4, set_flags=1 -> after one edge ALU_out=64'h0000_0000_0000_0002, nzcv=0000.
- Carry and overflow, both with set_flags=1:
  - ADD A=32'hFFFF_FFFF, B=1 -> result 0, nzcv=0110.
  - ADD A=32'h7FFF_FFFF, B=1 -> result 32'h8000_0000, nzcv=1001.
- Compares:
  - CMP A=5, B=5 -> nzcv=0110, regardless of set_flags.
  - CMP A=3, B=5 -> result 32'hFFFF_FFFE, nzcv=1000.
  - RSB A=3, B=5 -> 2, C=1.
- Carry chain:
  - Set C=1 via the first ADD above, then ADC A=1, B=1 -> 3.
  - SBC A=5, B=2 with C=0 -> 2.
  - ADD with set_flags=0 -> nzcv unchanged.
- Logical ops: with C=1,V=1 preset, BIC A=32'hFF, B=32'h0F, set_flags=1 -> 32'hF0, N=0, Z=0, C and V still 1. MVN B=32'hFFFF_FFFF -> 0, Z=1.
